// File: rtl/mips_pkg.sv
// Shared constants and dump sequencer state type for the MIPS register file.
package mips_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    IDLE,
    SEND
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_seq.sv
// Debug dump sequencer: streams every register, in index order, over valid/ready.
module regfile_dump_seq
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] idx_nxt;
  logic [DATA_W-1:0] data_nxt;

  // rd_addr always points at the index that would be captured on this edge,
  // so rd_data already carries any same-edge write through the bypass.
  always_comb begin
    state_nxt = state;
    idx_nxt   = dump_idx;
    data_nxt  = dump_data;
    rd_addr   = dump_idx + ADDR_W'(1);
    case (state)
      IDLE: begin
        rd_addr = '0;
        if (dump_start) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          data_nxt  = rd_data;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (dump_idx == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt  = rd_addr;
            data_nxt = rd_data;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      state     <= state_nxt;
      dump_idx  <= idx_nxt;
      dump_data <= data_nxt;
    end
  end

  assign dump_valid = (state == SEND);
  assign dump_busy  = (state == SEND);

endmodule

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file, r0 hard-wired to zero, write-to-read bypass.
// Optional dump sequencer compiled in with REGFILE_DUMP_EN.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];

  function automatic logic [DATA_W-1:0] bypass_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (addr == ZERO_ADDR)
      return '0;
    else if (wr_en && (wr_addr == addr))
      return wr_data;
    else
      return stored;
  endfunction

  // Entry 0 is cleared by reset and never written afterwards.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (we && (wa != ZERO_ADDR)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = bypass_read(ra1, regs[ra1], we, wa, wd);
  assign rd2 = bypass_read(ra2, regs[ra2], we, wa, wd);

`ifdef REGFILE_DUMP_EN
  logic [ADDR_W-1:0] dump_raddr;
  logic [DATA_W-1:0] dump_rdata;

  assign dump_rdata = bypass_read(dump_raddr, regs[dump_raddr], we, wa, wd);

  regfile_dump_seq #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dump_seq (
    .clk       (clk),
    .nrst      (nrst),
    .dump_start(dump_start),
    .dump_ready(dump_ready),
    .rd_addr   (dump_raddr),
    .rd_data   (dump_rdata),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_idx  (dump_idx),
    .dump_data (dump_data)
  );
`else
  logic unused_dump_in;
  assign unused_dump_in = &{1'b0, dump_start, dump_ready};

  assign dump_busy  = 1'b0;
  assign dump_valid = 1'b0;
  assign dump_idx   = '0;
  assign dump_data  = '0;
`endif

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile (dump scenarios under REGFILE_DUMP_EN).
module tb_mips_regfile;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic        we;
  logic        dump_start, dump_busy, dump_valid, dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_regfile dut (
    .clk       (clk),
    .nrst      (nrst),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .dump_start(dump_start),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_idx  (dump_idx),
    .dump_data (dump_data)
  );

  task automatic fill_regs();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; wa = 5'(i); wd = 32'(i * 32'h11);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    @(negedge clk);
    we = 1'b1; wa = 5'd4; wd = 32'hCAFE_F00D;
    @(negedge clk);
    we = 1'b0;
    tests++; if (dump_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", dump_busy); end
    tests++; if (dump_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", dump_valid); end
    tests++; if (dump_idx !== 5'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", dump_idx); end
    tests++; if (dump_data !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", dump_data); end
    ra1 = 5'd4; ra2 = 5'd31; #1;
    tests++; if (rd1 !== 32'd0) begin fails++; $display("FAIL reset_beats_write: got %h want 0", rd1); end
    tests++; if (rd2 !== 32'd0) begin fails++; $display("FAIL reset_rd2: got %h want 0", rd2); end
    nrst = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd6; #1;
    tests++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass_same_cycle: got %h want deadbeef", rd1); end
    tests++; if (rd2 !== 32'd0) begin fails++; $display("FAIL bypass_other_addr: got %h want 0", rd2); end
    @(negedge clk);
    we = 1'b0; ra2 = 5'd5; #1;
    tests++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stored_rd1: got %h want deadbeef", rd1); end
    tests++; if (rd2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stored_rd2: got %h want deadbeef", rd2); end
    wa = 5'd5; wd = 32'h0000_0001; #1;
    tests++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL no_bypass_we0: got %h want deadbeef", rd1); end
  endtask

  task automatic test_r0();
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0; #1;
    tests++; if (rd1 !== 32'd0) begin fails++; $display("FAIL r0_bypass_rd1: got %h want 0", rd1); end
    tests++; if (rd2 !== 32'd0) begin fails++; $display("FAIL r0_bypass_rd2: got %h want 0", rd2); end
    @(negedge clk);
    we = 1'b0; #1;
    tests++; if (rd1 !== 32'd0) begin fails++; $display("FAIL r0_stored_rd1: got %h want 0", rd1); end
    tests++; if (rd2 !== 32'd0) begin fails++; $display("FAIL r0_stored_rd2: got %h want 0", rd2); end
  endtask

`ifdef REGFILE_DUMP_EN
  task automatic test_dump_full();
    fill_regs();
    dump_ready = 1'b1;
    tests++; if (dump_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", dump_valid); end
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_idx !== 5'(k) || dump_data !== 32'(k * 32'h11)) begin
        fails++;
        $display("FAIL full_beat%0d: got v=%b b=%b idx=%0d data=%h want v=1 b=1 idx=%0d data=%h",
                 k, dump_valid, dump_busy, dump_idx, dump_data, k, 32'(k * 32'h11));
      end
      if (k < 31) @(negedge clk);
    end
    @(negedge clk);
    tests++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin fails++; $display("FAIL full_done: got b=%b v=%b want 0 0", dump_busy, dump_valid); end
    tests++; if (dump_idx !== 5'd31) begin fails++; $display("FAIL full_idx_hold: got %0d want 31", dump_idx); end
  endtask

  task automatic test_stall_write_reset();
    dump_ready = 1'b1; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    tests++; if (dump_idx !== 5'd7 || dump_data !== 32'h77) begin fails++; $display("FAIL stall_reach7: got idx=%0d data=%h want 7 77", dump_idx, dump_data); end
    dump_ready = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'h1234;
    @(negedge clk);
    we = 1'b0; ra1 = 5'd7; #1;
    tests++; if (dump_idx !== 5'd7 || dump_data !== 32'h77) begin fails++; $display("FAIL stall_hold1: got idx=%0d data=%h want 7 77", dump_idx, dump_data); end
    tests++; if (rd1 !== 32'h1234) begin fails++; $display("FAIL stall_reg7: got %h want 1234", rd1); end
    @(negedge clk);
    tests++; if (dump_valid !== 1'b1 || dump_idx !== 5'd7 || dump_data !== 32'h77) begin fails++; $display("FAIL stall_hold2: got v=%b idx=%0d data=%h want 1 7 77", dump_valid, dump_idx, dump_data); end
    we = 1'b1; wa = 5'd9; wd = 32'hABCD;
    @(negedge clk);
    we = 1'b0; dump_ready = 1'b1;
    tests++; if (dump_idx !== 5'd7 || dump_data !== 32'h77) begin fails++; $display("FAIL stall_hold3: got idx=%0d data=%h want 7 77", dump_idx, dump_data); end
    @(negedge clk);
    tests++; if (dump_idx !== 5'd8 || dump_data !== 32'h88) begin fails++; $display("FAIL after_stall8: got idx=%0d data=%h want 8 88", dump_idx, dump_data); end
    @(negedge clk);
    tests++; if (dump_idx !== 5'd9 || dump_data !== 32'hABCD) begin fails++; $display("FAIL late_write9: got idx=%0d data=%h want 9 abcd", dump_idx, dump_data); end
    we = 1'b1; wa = 5'd10; wd = 32'h5555;
    @(negedge clk);
    we = 1'b0;
    tests++; if (dump_idx !== 5'd10 || dump_data !== 32'h5555) begin fails++; $display("FAIL same_edge10: got idx=%0d data=%h want 10 5555", dump_idx, dump_data); end
    @(negedge clk);
    @(negedge clk);
    tests++; if (dump_idx !== 5'd12 || dump_data !== 32'hCC) begin fails++; $display("FAIL reach12: got idx=%0d data=%h want 12 cc", dump_idx, dump_data); end
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tests++; if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin fails++; $display("FAIL abort_flags: got v=%b b=%b want 0 0", dump_valid, dump_busy); end
    tests++; if (dump_idx !== 5'd0 || dump_data !== 32'd0) begin fails++; $display("FAIL abort_idx_data: got idx=%0d data=%h want 0 0", dump_idx, dump_data); end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i); #1;
      tests++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
        fails++; $display("FAIL abort_reg%0d: got rd1=%h rd2=%h want 0 0", i, rd1, rd2);
      end
    end
    @(negedge clk);
    tests++; if (dump_valid !== 1'b0) begin fails++; $display("FAIL abort_no_beats: got %b want 0", dump_valid); end
  endtask

  task automatic test_restart_ignored();
    fill_regs();
    dump_ready = 1'b1; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'(k) || dump_data !== 32'(k * 32'h11)) begin
        fails++;
        $display("FAIL restart_beat%0d: got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                 k, dump_valid, dump_idx, dump_data, k, 32'(k * 32'h11));
      end
      dump_start = (k == 20);
      if (k < 31) @(negedge clk);
    end
    @(negedge clk);
    tests++; if (dump_busy !== 1'b0) begin fails++; $display("FAIL restart_done: got %b want 0", dump_busy); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      tests++; if (dump_valid !== 1'b0) begin fails++; $display("FAIL restart_once%0d: got %b want 0", j, dump_valid); end
    end
  endtask
`else
  task automatic test_dump_disabled();
    dump_ready = 1'b1; dump_start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      tests++;
      if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
        fails++;
        $display("FAIL dump_tied%0d: got b=%b v=%b idx=%0d data=%h want all 0", j, dump_busy, dump_valid, dump_idx, dump_data);
      end
    end
    dump_start = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_r0();
`ifdef REGFILE_DUMP_EN
    test_dump_full();
    test_stall_write_reset();
    test_restart_ignored();
`else
    test_dump_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_regfile.md
# mips_regfile

- 32-entry × 32-bit MIPS general-purpose register file with two combinational read ports and one synchronous write port.
- Register 0 is hard-wired to zero; a same-cycle write is bypassed onto the read ports.
- A debug dump sequencer reads out all registers in index order over a valid/ready stream.
- The block sits between decode (read ports), write-back (write port) and the debug/trace logic (dump port).

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, index width; depth = 2^ADDR_W
- clk  in  1  clock, all state updates on rising edge
- nrst  in  1  reset, synchronous, active-low
- ra1  in  ADDR_W  read address, port 1
- ra2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1 (combinational)
- rd2  out  DATA_W  read data, port 2 (combinational)
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- dump_start  in  1  request a full register dump (single-cycle pulse or level)
- dump_busy  out  1  dump sequence in progress
- dump_valid  out  1  dump_idx/dump_data hold a valid beat
- dump_ready  in  1  consumer accepts the beat
- dump_idx  out  ADDR_W  index of the current beat
- dump_data  out  DATA_W  snapshot of register dump_idx

## Operation
- Write: on a clock edge with nrst=1, we=1 and wa≠0, the register at wa takes wd.
  - A write to wa=0 is discarded; register 0 always reads 0.
- Read: rdN = 0 if raN=0.
  - Else rdN = wd if we=1 and wa=raN (bypass).
  - Else rdN = stored value.
- Reset (nrst=0 at an edge) sets every register to 0 and puts the dump FSM in IDLE.
  - Reset values: dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0.
  - Reset takes priority over a concurrent write and over dump activity.
- Dump FSM states: IDLE, SEND.
  - IDLE → SEND when dump_start=1. dump_idx loads 0 and dump_data captures register 0 (value 0). dump_valid and dump_busy are set.
  - SEND with dump_valid & dump_ready and dump_idx < 2^ADDR_W−1: dump_idx increments and dump_data captures the new index. The captured value includes a same-edge write to that index.
  - SEND with a handshake at dump_idx = 2^ADDR_W−1: go to IDLE and clear dump_valid and dump_busy. dump_idx does not wrap and holds its last value until the next start.
  - SEND with dump_ready=0: dump_idx and dump_data hold stable. Writes to the register being presented do not alter dump_data.
  - dump_start while in SEND is ignored.
  - Writes are permitted throughout a dump. Indices not yet captured show post-write values.
- Reset mid-dump aborts the sequence immediately; no further beats are issued.

## Timing
- Read ports: zero latency, combinational from raN/we/wa/wd.
- Write: visible on rdN through the bypass in the same cycle, and from storage one cycle later.
- Dump:
  - First beat is valid the cycle after dump_start is sampled.
  - With dump_ready held high, one beat per cycle: 2^ADDR_W beats over 2^ADDR_W cycles.
  - dump_busy falls on the edge that accepts the last beat.
- Back-to-back dumps: dump_start is sampled in IDLE, so a new dump starts no earlier than one cycle after the previous dump_busy falls.

## Configuration
- REGFILE_DUMP_EN defined: the dump sequencer is compiled in as described above.
- REGFILE_DUMP_EN undefined: the dump ports still exist.
  - dump_busy, dump_valid, dump_idx and dump_data are tied to 0.
  - dump_start and dump_ready are ignored.
  - Only the register file logic is synthesized.

## Structure
- Shared package mips_pkg contains:
  - REG_W (32), REG_ADDR_W (5), REG_ZERO (0)
  - the dump FSM state enum (IDLE, SEND)
- Sub-module regfile_dump_seq holds the FSM, index counter and snapshot register.
  - It issues an internal read address and receives bypassed read data.
  - It is instantiated only under REGFILE_DUMP_EN.

## Test plan
- Write wa=5, wd=0xDEADBEEF, then ra1=5 → rd1=0xDEADBEEF in the same cycle (bypass) and in the next cycle (stored).
- Write wa=0, wd=0xFFFFFFFF; ra1=ra2=0 → rd1=rd2=0 in that cycle and afterwards.
- Fill reg i=i·0x11 for i=1..31, pulse dump_start with dump_ready=1 → 32 consecutive beats, idx 0..31, data 0,0x11,…,0x20F, then dump_busy=0.
- During a dump, hold dump_ready=0 at idx 7 and write reg 7=0x1234 → dump_data keeps the old value (0x77) until accepted.
  - Then write reg 9=0xABCD before it is captured → beat 9 carries 0xABCD.
- Assert nrst=0 at idx 12 → next cycle: dump_valid=0, dump_busy=0, dump_idx=0, and all registers read 0.
- Pulse dump_start again at idx 20 → ignored; the sequence continues to 31 and finishes exactly once.
